// File: rtl/iob_ultrasonic_ranger_pkg.sv
// rtl/iob_ultrasonic_ranger_pkg.sv - state encodings and shared constants for the ultrasonic ranger
package iob_ultrasonic_ranger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRIG      = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_MEASURE   = 2'd3
    } ranger_state_e;

    // Consecutive equal synchronized samples needed before the filtered echo changes level.
    localparam int FILTER_LEN = 4;

endpackage

// File: rtl/iob_ultrasonic_ranger_if.sv
// rtl/iob_ultrasonic_ranger_if.sv - request/status bundle between the GPIO side and the ranger
interface iob_ultrasonic_ranger_if #(
    parameter int CNT_W = 22
) ();
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             echo_valid_o;
    logic             timeout_o;
    logic [CNT_W-1:0] echo_cycles_o;

    modport master (
        output start_i,
        input  busy_o, done_o, echo_valid_o, timeout_o, echo_cycles_o
    );

    modport slave (
        input  start_i,
        output busy_o, done_o, echo_valid_o, timeout_o, echo_cycles_o
    );
endinterface

// File: rtl/iob_ranger_echo_filter.sv
// rtl/iob_ranger_echo_filter.sv - echo synchronizer with optional glitch filter (IOB_ULTRASONIC_RANGER_FILTER_EN)
module iob_ranger_echo_filter
    import iob_ultrasonic_ranger_pkg::*;
(
    input  logic clk,
    input  logic arst_n,
    input  logic echo_i,
    output logic echo_o
);
    logic [1:0] sync_q, sync_d;
    logic       echo_s;

    assign sync_d = {sync_q[0], echo_i};
    assign echo_s = sync_q[1];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) sync_q <= '0;
        else         sync_q <= sync_d;
    end

`ifdef IOB_ULTRASONIC_RANGER_FILTER_EN
    logic [FILTER_LEN-2:0] hist_q, hist_d;
    logic                  echo_f_q, echo_f_d;

    // The current sample plus FILTER_LEN-1 history samples must agree; the new level is
    // forwarded in the same cycle so both edges see exactly FILTER_LEN-1 cycles of delay.
    always_comb begin
        hist_d   = {hist_q[FILTER_LEN-3:0], echo_s};
        echo_f_d = echo_f_q;
        if (hist_q == {(FILTER_LEN-1){echo_s}}) echo_f_d = echo_s;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hist_q   <= '0;
            echo_f_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            echo_f_q <= echo_f_d;
        end
    end

    assign echo_o = echo_f_d;
`else
    assign echo_o = echo_s;
`endif

endmodule

// File: rtl/iob_ultrasonic_ranger.sv
// rtl/iob_ultrasonic_ranger.sv - HC-SR04 trigger/echo timer; IOB_ULTRASONIC_RANGER_FILTER_EN adds echo glitch filter
module iob_ultrasonic_ranger
    import iob_ultrasonic_ranger_pkg::*;
#(
    parameter int TRIG_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 3800000,
    parameter int CNT_W          = 22
) (
    input  logic                    clk,
    input  logic                    arst_n,
    iob_ultrasonic_ranger_if.slave  ctrl,
    input  logic                    sensor_echo_i,
    output logic                    sensor_trig_o
);
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ranger_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             trig_q, trig_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             echo_d_q;
    logic             echo;

    iob_ranger_echo_filter u_echo_filter (
        .clk    (clk),
        .arst_n (arst_n),
        .echo_i (sensor_echo_i),
        .echo_o (echo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        trig_d    = 1'b0;
        done_d    = 1'b0;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl.start_i) begin
                    state_d   = ST_TRIG;
                    cnt_d     = '0;
                    trig_d    = 1'b1;
                    valid_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    trig_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                // Edge detect on the registered copy: echo already high on entry never counts.
                if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end else if (echo && !echo_d_q) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                // A falling edge on the final cycle still counts as a successful measurement.
                if (!echo) begin
                    state_d  = ST_IDLE;
                    result_d = cnt_q;
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            echo_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            trig_q    <= trig_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            echo_d_q  <= echo;
        end
    end

    assign sensor_trig_o      = trig_q;
    assign ctrl.busy_o        = (state_q != ST_IDLE);
    assign ctrl.done_o        = done_q;
    assign ctrl.echo_valid_o  = valid_q;
    assign ctrl.timeout_o     = timeout_q;
    assign ctrl.echo_cycles_o = result_q;

endmodule

// File: tb/tb_iob_ultrasonic_ranger.sv
// tb/tb_iob_ultrasonic_ranger.sv - directed self-checking bench for iob_ultrasonic_ranger
module tb_iob_ultrasonic_ranger;
    localparam int TRIG_CYCLES    = 10;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int CNT_W          = 8;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic sensor_echo_i = 1'b0;
    logic sensor_trig_o;

    iob_ultrasonic_ranger_if #(.CNT_W(CNT_W)) ctrl ();

    iob_ultrasonic_ranger #(
        .TRIG_CYCLES    (TRIG_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .ctrl          (ctrl),
        .sensor_echo_i (sensor_echo_i),
        .sensor_trig_o (sensor_trig_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_total = 0;
    int last_done = -1;
    int t_fall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ctrl.done_o === 1'b1) begin
            done_total++;
            last_done = cyc;
        end
    endtask

    task automatic start_and_trig(output int tlen, output logic busy0);
        ctrl.start_i = 1'b1;
        tick();
        ctrl.start_i = 1'b0;
        busy0 = ctrl.busy_o;
        tlen = 0;
        for (int i = 0; i < 100; i++) begin
            if (sensor_trig_o) tlen++;
            else if (tlen > 0) break;
            tick();
        end
        t_fall = cyc;
    endtask

    task automatic pulse_echo(input int dly, input int len);
        repeat (dly) tick();
        sensor_echo_i = 1'b1;
        repeat (len) tick();
        sensor_echo_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trig"},    32'(sensor_trig_o),      0);
        check({tag, "_busy"},    32'(ctrl.busy_o),        0);
        check({tag, "_done"},    32'(ctrl.done_o),        0);
        check({tag, "_valid"},   32'(ctrl.echo_valid_o),  0);
        check({tag, "_timeout"}, 32'(ctrl.timeout_o),     0);
        check({tag, "_cycles"},  32'(ctrl.echo_cycles_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int   tlen;
        int   d0;
        logic busy0;

        // Reset held with start asserted
        ctrl.start_i = 1'b1;
        repeat (4) tick();
        check_reset_outputs("rst");
        ctrl.start_i = 1'b0;
        arst_n = 1'b1;
        repeat (3) tick();

        // Normal measurement: 57-cycle echo
        d0 = done_total;
        start_and_trig(tlen, busy0);
        check("t1_trig_len", tlen, 10);
        check("t1_busy", 32'(busy0), 1);
        pulse_echo(20, 57);
        repeat (30) tick();
        check("t1_done_cnt", done_total - d0, 1);
        check("t1_valid", 32'(ctrl.echo_valid_o), 1);
        check("t1_timeout", 32'(ctrl.timeout_o), 0);
        check("t1_cycles", 32'(ctrl.echo_cycles_o), 57);
        check("t1_idle", 32'(ctrl.busy_o), 0);

        // No echo: timeout after 200 WAIT_RISE cycles
        d0 = done_total;
        start_and_trig(tlen, busy0);
        repeat (260) tick();
        check("t3_done_cnt", done_total - d0, 1);
        check("t3_latency", last_done - t_fall, 200);
        check("t3_timeout", 32'(ctrl.timeout_o), 1);
        check("t3_valid", 32'(ctrl.echo_valid_o), 0);
        check("t3_cycles", 32'(ctrl.echo_cycles_o), 57);

        // Echo stuck high from before the trigger
        sensor_echo_i = 1'b1;
        repeat (5) tick();
        d0 = done_total;
        start_and_trig(tlen, busy0);
        repeat (260) tick();
        sensor_echo_i = 1'b0;
        repeat (5) tick();
        check("t4a_done_cnt", done_total - d0, 1);
        check("t4a_timeout", 32'(ctrl.timeout_o), 1);
        check("t4a_valid", 32'(ctrl.echo_valid_o), 0);

        // Echo rises then stays high past the timeout
        d0 = done_total;
        start_and_trig(tlen, busy0);
        pulse_echo(5, 250);
        repeat (20) tick();
        check("t4b_done_cnt", done_total - d0, 1);
        check("t4b_timeout", 32'(ctrl.timeout_o), 1);
        check("t4b_cycles", 32'(ctrl.echo_cycles_o), 57);

        // start pulses during TRIG and MEASURE are ignored
        d0 = done_total;
        ctrl.start_i = 1'b1;
        tick();
        ctrl.start_i = 1'b0;
        repeat (3) tick();
        ctrl.start_i = 1'b1;
        tick();
        ctrl.start_i = 1'b0;
        repeat (20) tick();
        sensor_echo_i = 1'b1;
        repeat (10) tick();
        ctrl.start_i = 1'b1;
        tick();
        ctrl.start_i = 1'b0;
        repeat (19) tick();
        sensor_echo_i = 1'b0;
        repeat (40) tick();
        check("t5_done_cnt", done_total - d0, 1);
        check("t5_valid", 32'(ctrl.echo_valid_o), 1);
        check("t5_cycles", 32'(ctrl.echo_cycles_o), 30);

        // Asynchronous reset in TRIG drops the trigger without a clock edge
        ctrl.start_i = 1'b1;
        tick();
        ctrl.start_i = 1'b0;
        tick();
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check("t5_async_trig", 32'(sensor_trig_o), 0);
        check("t5_async_busy", 32'(ctrl.busy_o), 0);
        tick();
        arst_n = 1'b1;
        repeat (3) tick();

        // Reset in the middle of MEASURE
        start_and_trig(tlen, busy0);
        pulse_echo(5, 0);
        sensor_echo_i = 1'b1;
        repeat (15) tick();
        arst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst_meas");
        sensor_echo_i = 1'b0;
        tick();
        arst_n = 1'b1;
        repeat (3) tick();

        // 2-cycle glitch followed by a 40-cycle pulse
        d0 = done_total;
        start_and_trig(tlen, busy0);
        pulse_echo(5, 2);
        pulse_echo(10, 40);
        repeat (40) tick();
        check("t6_valid", 32'(ctrl.echo_valid_o), 1);
`ifdef IOB_ULTRASONIC_RANGER_FILTER_EN
        check("t6_cycles", 32'(ctrl.echo_cycles_o), 40);
`else
        check("t6_cycles", 32'(ctrl.echo_cycles_o), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
